// File: rtl/div_unit_cdb.sv
// div_unit_cdb: Tomasulo divide functional unit with three reservation
// stations and the common data bus arbiter. Only one unsigned division
// runs at a time.
//
// State table for the divider FSM:
//   state    | meaning
//   DIV_IDLE | no division running; a ready station may start
//   DIV_EXEC | quotient latched, latency counter running down
//   DIV_HOLD | result pending on cdb_request/cdb_out until granted
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   issue, q1_in, q2_in,
//   v1_in, v2_in                 divide issue with operand tags/values
//   alu/mul/ls_cdb_request,
//   alu/mul/ls_cdb_in            external CDB requests {tag, data}
//   all_busy                     all three stations occupied
//   cdb_request, cdb_out         pending divide result {tag, quotient}
//   cdb                          registered bus {valid, tag, data}
module div_unit_cdb #(
  parameter int         DIV_LATENCY = 4,
  parameter logic [4:0] UNIT_ID     = 5'b00100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [7:0]  q1_in,
  input  logic [7:0]  q2_in,
  input  logic [31:0] v1_in,
  input  logic [31:0] v2_in,
  input  logic        alu_cdb_request,
  input  logic        mul_cdb_request,
  input  logic        ls_cdb_request,
  input  logic [39:0] alu_cdb_in,
  input  logic [39:0] mul_cdb_in,
  input  logic [39:0] ls_cdb_in,
  output logic        all_busy,
  output logic        cdb_request,
  output logic [39:0] cdb_out,
  output logic [40:0] cdb
);

  localparam int CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_EXEC, DIV_HOLD} div_state_t;

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       cur_idx;
  logic [31:0]      quot;

  logic [2:0]  rs_busy, rs_exec, rs_ready;
  logic [7:0]  rs_q1 [3];
  logic [7:0]  rs_q2 [3];
  logic [31:0] rs_v1 [3];
  logic [31:0] rs_v2 [3];

  logic        cdb_valid;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [2:0]  cur_lo;
  logic        granted, issue_ok, start;
  logic [1:0]  issue_idx, start_idx;
  logic [31:0] sel_v1, sel_v2, sel_quot;

  assign cdb_valid = cdb[40];
  assign cdb_tag   = cdb[39:32];
  assign cdb_data  = cdb[31:0];

  assign cur_lo   = 3'(cur_idx) + 3'd1;
  // Our own tag on the bus is the grant; drop the request in that cycle so
  // the arbiter never broadcasts the same result twice.
  assign granted     = (state == DIV_HOLD) && cdb_valid && (cdb_tag == {UNIT_ID, cur_lo});
  assign cdb_request = (state == DIV_HOLD) && !granted;
  assign cdb_out     = (state == DIV_HOLD) ? {UNIT_ID, cur_lo, quot} : 40'd0;

  assign all_busy = &rs_busy;
  assign issue_ok = issue && !all_busy;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rs_ready[i] = rs_busy[i] && !rs_exec[i] && (rs_q1[i] == 8'd0) && (rs_q2[i] == 8'd0);
    end
  end

  always_comb begin
    issue_idx = 2'd2;
    if (!rs_busy[0])      issue_idx = 2'd0;
    else if (!rs_busy[1]) issue_idx = 2'd1;
  end

  always_comb begin
    start_idx = 2'd0;
    sel_v1    = rs_v1[0];
    sel_v2    = rs_v2[0];
    if (rs_ready[0]) begin
      start_idx = 2'd0;
    end else if (rs_ready[1]) begin
      start_idx = 2'd1;
      sel_v1    = rs_v1[1];
      sel_v2    = rs_v2[1];
    end else begin
      start_idx = 2'd2;
      sel_v1    = rs_v1[2];
      sel_v2    = rs_v2[2];
    end
  end

  assign sel_quot = (sel_v2 == 32'd0) ? 32'hFFFF_FFFF : sel_v1 / sel_v2;

  // A new division may start on the same edge the previous result is granted.
  assign start = ((state == DIV_IDLE) || granted) && (|rs_ready);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      DIV_IDLE: ;
      DIV_EXEC: begin
        if (cnt == CNT_W'(1)) state_nx = DIV_HOLD;
        else                  cnt_nx   = cnt - CNT_W'(1);
      end
      DIV_HOLD: if (granted) state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
    if (start) begin
      state_nx = (DIV_LATENCY == 1) ? DIV_HOLD : DIV_EXEC;
      cnt_nx   = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      cur_idx <= 2'd0;
      quot    <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start) begin
        cur_idx <= start_idx;
        quot    <= sel_quot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_busy <= 3'b000;
      rs_exec <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        rs_q1[i] <= 8'd0;
        rs_q2[i] <= 8'd0;
        rs_v1[i] <= 32'd0;
        rs_v2[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (granted && (cur_idx == 2'(i))) begin
          rs_busy[i] <= 1'b0;
          rs_exec[i] <= 1'b0;
        end else if (rs_busy[i]) begin
          if (cdb_valid && (cdb_tag != 8'd0) && (rs_q1[i] == cdb_tag)) begin
            rs_q1[i] <= 8'd0;
            rs_v1[i] <= cdb_data;
          end
          if (cdb_valid && (cdb_tag != 8'd0) && (rs_q2[i] == cdb_tag)) begin
            rs_q2[i] <= 8'd0;
            rs_v2[i] <= cdb_data;
          end
          if (start && (start_idx == 2'(i))) rs_exec[i] <= 1'b1;
        end else if (issue_ok && (issue_idx == 2'(i))) begin
          rs_busy[i] <= 1'b1;
          rs_exec[i] <= 1'b0;
          // Operand broadcast on the issue edge is captured directly.
          if (cdb_valid && (q1_in != 8'd0) && (cdb_tag == q1_in)) begin
            rs_q1[i] <= 8'd0;
            rs_v1[i] <= cdb_data;
          end else begin
            rs_q1[i] <= q1_in;
            rs_v1[i] <= v1_in;
          end
          if (cdb_valid && (q2_in != 8'd0) && (cdb_tag == q2_in)) begin
            rs_q2[i] <= 8'd0;
            rs_v2[i] <= cdb_data;
          end else begin
            rs_q2[i] <= q2_in;
            rs_v2[i] <= v2_in;
          end
        end
      end
    end
  end

  // Fixed priority: ALU > mul > div > load/store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb <= 41'd0;
    end else if (alu_cdb_request) begin
      cdb <= {1'b1, alu_cdb_in};
    end else if (mul_cdb_request) begin
      cdb <= {1'b1, mul_cdb_in};
    end else if (cdb_request) begin
      cdb <= {1'b1, cdb_out};
    end else if (ls_cdb_request) begin
      cdb <= {1'b1, ls_cdb_in};
    end else begin
      cdb <= 41'd0;
    end
  end

endmodule

// File: tb/tb_div_unit_cdb.sv
module tb_div_unit_cdb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue = 1'b0;
  logic [7:0]  q1_in = 8'd0, q2_in = 8'd0;
  logic [31:0] v1_in = 32'd0, v2_in = 32'd0;
  logic        alu_cdb_request = 1'b0, mul_cdb_request = 1'b0, ls_cdb_request = 1'b0;
  logic [39:0] alu_cdb_in = 40'd0, mul_cdb_in = 40'd0, ls_cdb_in = 40'd0;
  logic        all_busy, cdb_request;
  logic [39:0] cdb_out;
  logic [40:0] cdb;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] RS1 = 8'h21, RS2 = 8'h22, RS3 = 8'h23, ALU_TAG = 8'h09;

  div_unit_cdb #(.DIV_LATENCY(4), .UNIT_ID(5'b00100)) dut (
    .clk(clk), .rst(rst), .issue(issue),
    .q1_in(q1_in), .q2_in(q2_in), .v1_in(v1_in), .v2_in(v2_in),
    .alu_cdb_request(alu_cdb_request), .mul_cdb_request(mul_cdb_request),
    .ls_cdb_request(ls_cdb_request),
    .alu_cdb_in(alu_cdb_in), .mul_cdb_in(mul_cdb_in), .ls_cdb_in(ls_cdb_in),
    .all_busy(all_busy), .cdb_request(cdb_request), .cdb_out(cdb_out), .cdb(cdb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_issue(input logic [7:0] q1, input logic [7:0] q2,
                          input logic [31:0] v1, input logic [31:0] v2);
    issue = 1'b1; q1_in = q1; q2_in = q2; v1_in = v1; v2_in = v2;
    step(1);
    issue = 1'b0; q1_in = 8'd0; q2_in = 8'd0; v1_in = 32'd0; v2_in = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (cdb !== 41'd0) begin failures++; $display("FAIL reset_cdb: got %h want 0", cdb); end
    checks++; if (cdb_request !== 1'b0 || all_busy !== 1'b0) begin failures++; $display("FAIL reset_flags: got req=%b busy=%b want 0 0", cdb_request, all_busy); end
    checks++; if (cdb_out !== 40'd0) begin failures++; $display("FAIL reset_cdb_out: got %h want 0", cdb_out); end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Issue v1/v2 with ready operands; result on cdb DIV_LATENCY+1 edges later.
  task automatic test_divide(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] q);
    do_issue(8'd0, 8'd0, v1, v2);
    step(3);
    checks++; if (cdb_request !== 1'b0) begin failures++; $display("FAIL div_early_req: got %b want 0", cdb_request); end
    step(1);
    checks++; if (cdb_request !== 1'b1 || cdb_out !== {RS1, q}) begin failures++; $display("FAIL div_req: got req=%b out=%h want 1 %h", cdb_request, cdb_out, {RS1, q}); end
    step(1);
    checks++; if (cdb !== {1'b1, RS1, q}) begin failures++; $display("FAIL div_cdb: got %h want %h", cdb, {1'b1, RS1, q}); end
    checks++; if (cdb_request !== 1'b0) begin failures++; $display("FAIL div_req_drop: got %b want 0", cdb_request); end
    step(1);
    checks++; if (cdb !== 41'd0) begin failures++; $display("FAIL div_cdb_idle: got %h want 0", cdb); end
  endtask

  task automatic test_wakeup();
    do_issue(8'd0, ALU_TAG, 32'd20, 32'd0);
    alu_cdb_request = 1'b1; alu_cdb_in = {ALU_TAG, 32'd4};
    step(1);
    checks++; if (cdb !== {1'b1, ALU_TAG, 32'd4}) begin failures++; $display("FAIL wake_alu_cdb: got %h want %h", cdb, {1'b1, ALU_TAG, 32'd4}); end
    alu_cdb_request = 1'b0;
    step(4);
    checks++; if (cdb_request !== 1'b0) begin failures++; $display("FAIL wake_early_req: got %b want 0", cdb_request); end
    step(1);
    checks++; if (cdb_request !== 1'b1 || cdb_out !== {RS1, 32'd5}) begin failures++; $display("FAIL wake_req: got req=%b out=%h want 1 %h", cdb_request, cdb_out, {RS1, 32'd5}); end
    step(1);
    checks++; if (cdb !== {1'b1, RS1, 32'd5}) begin failures++; $display("FAIL wake_cdb: got %h want %h", cdb, {1'b1, RS1, 32'd5}); end
    step(1);
  endtask

  task automatic test_arbitration();
    do_issue(8'd0, 8'd0, 32'd100, 32'd7);
    step(4);
    checks++; if (cdb_request !== 1'b1) begin failures++; $display("FAIL arb_req: got %b want 1", cdb_request); end
    alu_cdb_request = 1'b1; alu_cdb_in = {ALU_TAG, 32'h0000CAFE};
    step(1);
    checks++; if (cdb !== {1'b1, ALU_TAG, 32'h0000CAFE}) begin failures++; $display("FAIL arb_alu_first: got %h want %h", cdb, {1'b1, ALU_TAG, 32'h0000CAFE}); end
    checks++; if (cdb_request !== 1'b1 || cdb_out !== {RS1, 32'd14}) begin failures++; $display("FAIL arb_hold: got req=%b out=%h want 1 %h", cdb_request, cdb_out, {RS1, 32'd14}); end
    alu_cdb_request = 1'b0;
    step(1);
    checks++; if (cdb !== {1'b1, RS1, 32'd14}) begin failures++; $display("FAIL arb_div_second: got %h want %h", cdb, {1'b1, RS1, 32'd14}); end
    step(1);
    checks++; if (cdb !== 41'd0 || cdb_request !== 1'b0) begin failures++; $display("FAIL arb_idle: got cdb=%h req=%b want 0 0", cdb, cdb_request); end
  endtask

  task automatic test_bypass();
    alu_cdb_request = 1'b1; alu_cdb_in = {8'h11, 32'd90};
    step(1);
    alu_cdb_request = 1'b0;
    do_issue(8'h11, 8'd0, 32'd0, 32'd9);
    step(4);
    checks++; if (cdb_request !== 1'b1 || cdb_out !== {RS1, 32'd10}) begin failures++; $display("FAIL bypass_req: got req=%b out=%h want 1 %h", cdb_request, cdb_out, {RS1, 32'd10}); end
    step(1);
    checks++; if (cdb !== {1'b1, RS1, 32'd10}) begin failures++; $display("FAIL bypass_cdb: got %h want %h", cdb, {1'b1, RS1, 32'd10}); end
    step(1);
  endtask

  // RS1 waits on its own tag and never wakes; RS2/RS3 complete in order.
  task automatic test_back_to_back();
    do_issue(RS1, 8'd0, 32'd0, 32'd2);
    do_issue(8'd0, 8'd0, 32'd2, 32'd3);
    do_issue(8'd0, 8'd0, 32'd4, 32'd5);
    checks++; if (all_busy !== 1'b1) begin failures++; $display("FAIL b2b_all_busy: got %b want 1", all_busy); end
    step(3);
    checks++; if (cdb_request !== 1'b1 || cdb_out !== {RS2, 32'd0}) begin failures++; $display("FAIL b2b_req_rs2: got req=%b out=%h want 1 %h", cdb_request, cdb_out, {RS2, 32'd0}); end
    step(1);
    checks++; if (cdb !== {1'b1, RS2, 32'd0}) begin failures++; $display("FAIL b2b_cdb_rs2: got %h want %h", cdb, {1'b1, RS2, 32'd0}); end
    step(1);
    checks++; if (all_busy !== 1'b0 || cdb !== 41'd0) begin failures++; $display("FAIL b2b_rs2_freed: got busy=%b cdb=%h want 0 0", all_busy, cdb); end
    step(4);
    checks++; if (cdb !== {1'b1, RS3, 32'd0}) begin failures++; $display("FAIL b2b_cdb_rs3: got %h want %h", cdb, {1'b1, RS3, 32'd0}); end
    step(1);
    checks++; if (cdb !== 41'd0 || cdb_request !== 1'b0) begin failures++; $display("FAIL b2b_idle: got cdb=%h req=%b want 0 0", cdb, cdb_request); end
    do_issue(8'd0, 8'd0, 32'd40, 32'd8);
    checks++; if (all_busy !== 1'b0) begin failures++; $display("FAIL b2b_one_free: got %b want 0", all_busy); end
    do_issue(8'd0, 8'd0, 32'd9, 32'd3);
    checks++; if (all_busy !== 1'b1) begin failures++; $display("FAIL b2b_rs1_stuck: got %b want 1", all_busy); end
  endtask

  // Continues from test_back_to_back: RS2 (40/8) started on the last issue edge.
  task automatic test_reset_mid_division();
    step(2);
    alu_cdb_request = 1'b1; alu_cdb_in = {ALU_TAG, 32'd77};
    step(1);
    checks++; if (cdb !== {1'b1, ALU_TAG, 32'd77} || cdb_request !== 1'b1 || cdb_out !== {RS2, 32'd5}) begin failures++; $display("FAIL mid_pre_reset: got cdb=%h req=%b out=%h want %h 1 %h", cdb, cdb_request, cdb_out, {1'b1, ALU_TAG, 32'd77}, {RS2, 32'd5}); end
    alu_cdb_request = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (cdb !== 41'd0 || cdb_out !== 40'd0) begin failures++; $display("FAIL mid_reset_bus: got cdb=%h out=%h want 0 0", cdb, cdb_out); end
    checks++; if (cdb_request !== 1'b0 || all_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_flags: got req=%b busy=%b want 0 0", cdb_request, all_busy); end
    #2;
    rst = 1'b0;
    step(2);
    checks++; if (all_busy !== 1'b0 || cdb_request !== 1'b0) begin failures++; $display("FAIL post_reset: got busy=%b req=%b want 0 0", all_busy, cdb_request); end
  endtask

  initial begin
    test_reset();
    test_divide(32'd100, 32'd7, 32'd14);
    test_divide(32'd5, 32'd0, 32'hFFFF_FFFF);
    test_wakeup();
    test_arbitration();
    test_bypass();
    test_back_to_back();
    test_reset_mid_division();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
